song_sequencer: RTL and testbench
=================================

# song_sequencer

Parametrised, RAM-backed successor to the fixed single-song note ROM. It stores up to 2**SEL_W songs of note codes, each with a programmable length, and steps through the selected song at one slot per BEAT_DIV clocks. It adds play/pause/stop control, loop mode and an onset pulse for envelope triggering. It sits between the control/keypad logic and the tone generator, which consumes `note`, `note_valid` and `onset`.

## Interface
Parameters:
- NOTE_W, 12, note code width; nibble [11:8] = high octave degree, [7:4] = middle, [3:0] = low; 0 = rest
- ADDR_W, 6, slot address width; each song has up to 2**ADDR_W slots
- SEL_W, 2, song select width; 2**SEL_W songs
- BEAT_DIV, 12500000, clocks per slot; must be ≥2
- TIMER_W, 24, slot timer width; must satisfy 2**TIMER_W ≥ BEAT_DIV

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  note RAM write strobe
- wr_song  in  SEL_W  song for wr_en / len_we
- wr_addr  in  ADDR_W  slot written
- wr_data  in  NOTE_W  note code written
- len_we  in  1  song length write strobe
- len_data  in  ADDR_W+1  song length in slots; values above 2**ADDR_W are stored as 2**ADDR_W
- song_sel  in  SEL_W  song to play; sampled only on an accepted `play` from IDLE
- loop_en  in  1  wrap to slot 0 at song end; sampled at each song-end boundary
- play, pause, stop  in  1 each  single-cycle command pulses
- note  out  NOTE_W  current note code
- note_valid  out  1  `note` is sounding
- onset  out  1  one-cycle pulse on a new non-rest note
- slot_addr  out  ADDR_W  current slot
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when a non-looping song ends

## Operation
- Storage:
  - The note RAM holds 2**(SEL_W+ADDR_W) words with a synchronous registered read (`ram_q`).
  - There is one length register per song.
  - The RAM has no reset. All length registers reset to 0.
- States: IDLE, RD, LD, PLAY, PAUSE.
- Command priority: stop > pause > play.
  - `stop` in any state: go to IDLE, `note`←0, `note_valid`←0, `onset`←0, `slot_addr`←0. `done` is not pulsed.
- IDLE + `play`:
  - If len[song_sel] = 0: ignore the command and stay in IDLE.
  - Otherwise: latch the song, `slot_addr`←0, go to RD.
- RD: read address is slot 0. Go to LD.
- LD: `note`←`ram_q`, `note_valid`←1, `onset`←(`ram_q`≠0), timer←0. Go to PLAY.
- PLAY:
  - Read address is prefetched continuously: 0 if `slot_addr`=len−1, else `slot_addr`+1.
  - The timer increments every clock. At timer = BEAT_DIV−1 (the slot boundary), timer←0.
  - At a boundary on the last slot with `loop_en`=0: go to IDLE, `note`←0, `note_valid`←0, pulse `done`.
  - At any other boundary: `slot_addr`←prefetch address, `note`←`ram_q`, `onset`←(`ram_q`≠0 && `ram_q`≠`note`).
  - Identical consecutive codes form a tied note and produce no onset.
- PLAY + `pause`: go to PAUSE. Timer, `slot_addr` and `note` are frozen. `note_valid`←0.
- PAUSE + `play`: go to PLAY, `note_valid`←1, no onset. The timer resumes from its frozen value.
- `play` while in PLAY, RD or LD is ignored. `pause` outside PLAY is ignored.
- Length writes during playback take effect at the next boundary comparison.
  - If the new length is ≤ `slot_addr`, the song ends (or wraps, if looping) at the next boundary.

## Timing
- Reset values: `note`=0, `note_valid`=0, `onset`=0, `slot_addr`=0, `busy`=0, `done`=0; state IDLE; timer 0.
- Start latency: `play` sampled at edge E0 → RD; E1 → LD; at E2 `note`/`note_valid`/`onset` update. Outputs are valid 2 clocks after `play`.
- Every slot lasts exactly BEAT_DIV clocks, including the loop wrap. There are no gap cycles between slots.
- `onset` and `done` are high for exactly one clock.
- Write/read hazard:
  - A RAM write at edge W is seen by a boundary at edge B only if W ≤ B−2.
  - A write in the last clock before a boundary to the prefetched slot takes effect on the next visit to that slot.
- Simultaneous `wr_en` and `len_we` are both performed.

## Test plan
- BEAT_DIV=4. Load song 0 with slots {0x005, 0x005, 0x030}, len=3. Pulse `play` → `note` sequence 0x005 ×8 clocks, then 0x030 ×4. `onset` pulses at start only, then at 0x030. `done` pulses once, then `busy`=0 and `note`=0.
- Same song with `loop_en`=1 → after 0x030 the output wraps to 0x005 with no gap, and `onset` pulses at the wrap. `stop` → IDLE next clock with no `done` pulse.
- Pause in the 2nd clock of slot 1, hold 10 clocks, then `play` → `note_valid` is low for the paused interval. On resume, slot 1 lasts its remaining 2 clocks and there is no extra onset.
- `play` with len[song_sel]=0 → `busy` stays 0. Simultaneous `stop`+`pause`+`play` in PLAY → IDLE.
- Song 1 (len=2, codes 0x100 and 0x000) → the rest slot gives `note`=0, `note_valid`=1, `onset`=0.
- Assert `rst_n` low mid-slot → all outputs return to 0 asynchronously. Length registers read back 0: a subsequent `play` is ignored.

Source files
------------

// File: rtl/song_sequencer.sv
// ============================================================================
// song_sequencer : RAM-backed multi-song note sequencer with play/pause/stop,
//                  loop mode, per-note onset pulse and end-of-song pulse.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module song_sequencer #(
    parameter int NOTE_W   = 12,
    parameter int ADDR_W   = 6,
    parameter int SEL_W    = 2,
    parameter int BEAT_DIV = 12500000,
    parameter int TIMER_W  = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_song,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [NOTE_W-1:0]   wr_data,
    input  logic                len_we,
    input  logic [ADDR_W:0]     len_data,
    input  logic [SEL_W-1:0]    song_sel,
    input  logic                loop_en,
    input  logic                play,
    input  logic                pause,
    input  logic                stop,
    output logic [NOTE_W-1:0]   note,
    output logic                note_valid,
    output logic                onset,
    output logic [ADDR_W-1:0]   slot_addr,
    output logic                busy,
    output logic                done
);

    localparam int                c_DEPTH     = 2**(SEL_W+ADDR_W);
    localparam int                c_NSONG     = 2**SEL_W;
    localparam logic [ADDR_W:0]   c_MAX_LEN   = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [TIMER_W-1:0] c_LAST_TICK = TIMER_W'(BEAT_DIV-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LD    = 3'd2,
        S_PLAY  = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t               r_state;
    logic [NOTE_W-1:0]    r_ram [c_DEPTH];
    logic [NOTE_W-1:0]    r_ram_q;
    logic [ADDR_W:0]      r_len [c_NSONG];
    logic [SEL_W-1:0]     r_song;
    logic [TIMER_W-1:0]   r_timer;

    logic [ADDR_W:0]      w_len_clamp;
    logic [ADDR_W:0]      w_cur_len;
    logic                 w_last;
    logic [ADDR_W-1:0]    w_next_slot;
    logic [ADDR_W-1:0]    w_rd_addr;
    logic                 w_boundary;
    logic                 w_start_ok;

    assign w_len_clamp = (len_data > c_MAX_LEN) ? c_MAX_LEN : len_data;
    assign w_cur_len   = r_len[r_song];
    // ">=" rather than "==" so a length shrunk below the current slot still ends the song
    assign w_last      = (({1'b0, slot_addr} + (ADDR_W+1)'(1)) >= w_cur_len);
    assign w_next_slot = w_last ? '0 : slot_addr + ADDR_W'(1);
    assign w_rd_addr   = (r_state == S_PLAY || r_state == S_PAUSE) ? w_next_slot : '0;
    assign w_boundary  = (r_timer == c_LAST_TICK);
    assign w_start_ok  = (r_len[song_sel] != '0);
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_ram[{wr_song, wr_addr}] <= wr_data;
        end
        r_ram_q <= r_ram[{r_song, w_rd_addr}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NSONG; i++) begin
                r_len[i] <= '0;
            end
        end else if (len_we) begin
            r_len[wr_song] <= w_len_clamp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_song     <= '0;
            r_timer    <= '0;
            note       <= '0;
            note_valid <= 1'b0;
            onset      <= 1'b0;
            slot_addr  <= '0;
            done       <= 1'b0;
        end else begin
            onset <= 1'b0;
            done  <= 1'b0;
            if (stop) begin
                r_state    <= S_IDLE;
                r_timer    <= '0;
                note       <= '0;
                note_valid <= 1'b0;
                slot_addr  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (play && w_start_ok) begin
                            r_song    <= song_sel;
                            slot_addr <= '0;
                            r_state   <= S_RD;
                        end
                    end
                    S_RD: begin
                        r_state <= S_LD;
                    end
                    S_LD: begin
                        note       <= r_ram_q;
                        note_valid <= 1'b1;
                        onset      <= (r_ram_q != '0);
                        r_timer    <= '0;
                        r_state    <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (pause) begin
                            // The pausing clock still counts as played time
                            r_state    <= S_PAUSE;
                            note_valid <= 1'b0;
                            if (!w_boundary) begin
                                r_timer <= r_timer + TIMER_W'(1);
                            end
                        end else if (w_boundary) begin
                            r_timer <= '0;
                            if (w_last && !loop_en) begin
                                r_state    <= S_IDLE;
                                note       <= '0;
                                note_valid <= 1'b0;
                                done       <= 1'b1;
                            end else begin
                                slot_addr <= w_next_slot;
                                note      <= r_ram_q;
                                onset     <= (r_ram_q != '0) && (r_ram_q != note);
                            end
                        end else begin
                            r_timer <= r_timer + TIMER_W'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (play) begin
                            r_state    <= S_PLAY;
                            note_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_song_sequencer.sv
// ============================================================================
// tb_song_sequencer : directed table-driven bench for song_sequencer
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_song_sequencer;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_song;
    logic [5:0]  wr_addr;
    logic [11:0] wr_data;
    logic        len_we;
    logic [6:0]  len_data;
    logic [1:0]  song_sel;
    logic        loop_en;
    logic        play;
    logic        pause;
    logic        stop;
    logic [11:0] note;
    logic        note_valid;
    logic        onset;
    logic [5:0]  slot_addr;
    logic        busy;
    logic        done;

    song_sequencer #(
        .NOTE_W   (12),
        .ADDR_W   (6),
        .SEL_W    (2),
        .BEAT_DIV (4),
        .TIMER_W  (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_song    (wr_song),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .len_we     (len_we),
        .len_data   (len_data),
        .song_sel   (song_sel),
        .loop_en    (loop_en),
        .play       (play),
        .pause      (pause),
        .stop       (stop),
        .note       (note),
        .note_valid (note_valid),
        .onset      (onset),
        .slot_addr  (slot_addr),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        play;
        logic        pause;
        logic        stop;
        logic        loop_en;
        logic [11:0] note;
        logic        nv;
        logic        onset;
        logic [5:0]  slot;
        logic        chk_slot;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic pl, logic pa, logic st, logic lp,
                                logic [11:0] n, logic nv, logic on,
                                logic [5:0] sl, logic cs, logic b, logic d);
        vec_t v;
        v.play = pl; v.pause = pa; v.stop = st; v.loop_en = lp;
        v.note = n; v.nv = nv; v.onset = on; v.slot = sl; v.chk_slot = cs;
        v.busy = b; v.done = d;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(string name, logic [11:0] n, logic nv, logic on,
                              logic [5:0] sl, logic cs, logic b, logic d);
        logic [21:0] got;
        logic [21:0] exp;
        got = {note, note_valid, onset, (cs ? slot_addr : 6'd0), busy, done};
        exp = {n, nv, on, (cs ? sl : 6'd0), b, d};
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got note=%h nv=%b onset=%b slot=%0d busy=%b done=%b, expected note=%h nv=%b onset=%b slot=%0d busy=%b done=%b",
                     name, got[21:10], got[9], got[8], got[7:2], got[1], got[0],
                     exp[21:10], exp[9], exp[8], exp[7:2], exp[1], exp[0]);
        end
    endtask

    task automatic wr_note(input logic [1:0] s, input logic [5:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_song = s; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic set_len(input logic [1:0] s, input logic [6:0] l);
        len_we = 1'b1; wr_song = s; len_data = l;
        step();
        len_we = 1'b0;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        step();
        play = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_song = '0; wr_addr = '0; wr_data = '0;
        len_we = 1'b0; len_data = '0; song_sel = '0; loop_en = 1'b0;
        play = 1'b0; pause = 1'b0; stop = 1'b0;

        // Song 0 plain, then looped: start latency, tie, end/wrap, stop
        for (int lp = 0; lp < 2; lp++) begin
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'(lp), 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0));
            vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'(lp), 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0));
            for (int s = 0; s < 3; s++) begin
                for (int t = 0; t < 4; t++) begin
                    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'(lp), (s == 2) ? 12'h030 : 12'h005,
                                      1'b1, (t == 0) && (s != 1), 6'(s), 1'b1, 1'b1, 1'b0));
                end
            end
            if (lp == 0) begin
                vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1));
                vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0));
            end else begin
                vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h005, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 1'b0));
                vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h005, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0));
                vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0));
                vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0));
            end
        end

        step();
        step();
        expect_out("reset", 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        wr_note(2'd0, 6'd0, 12'h005);
        wr_note(2'd0, 6'd1, 12'h005);
        wr_note(2'd0, 6'd2, 12'h030);
        set_len(2'd0, 7'd3);
        wr_note(2'd1, 6'd0, 12'h100);
        wr_note(2'd1, 6'd1, 12'h000);
        set_len(2'd1, 7'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            play = vecs[i].play; pause = vecs[i].pause; stop = vecs[i].stop;
            loop_en = vecs[i].loop_en;
            step();
            play = 1'b0; pause = 1'b0; stop = 1'b0;
            expect_out($sformatf("vec%0d", i), vecs[i].note, vecs[i].nv, vecs[i].onset,
                       vecs[i].slot, vecs[i].chk_slot, vecs[i].busy, vecs[i].done);
        end
        loop_en = 1'b0;

        // Pause in the 2nd clock of slot 1, resume, remaining 2 clocks
        song_sel = 2'd0;
        pulse_play();
        for (int k = 0; k < 7; k++) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        expect_out("pause_enter", 12'h005, 1'b0, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step();
            expect_out("pause_hold", 12'h005, 1'b0, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0);
        end
        pulse_play();
        expect_out("resume", 12'h005, 1'b1, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("resume_tail", 12'h005, 1'b1, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("resume_next", 12'h030, 1'b1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_out("stop_nodone", 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

        // stop beats pause and play when all arrive together
        pulse_play();
        step();
        step();
        stop = 1'b1; pause = 1'b1; play = 1'b1;
        step();
        stop = 1'b0; pause = 1'b0; play = 1'b0;
        expect_out("stop_pause_play", 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

        // Zero-length song cannot start
        song_sel = 2'd2;
        pulse_play();
        expect_out("len0_a", 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("len0_b", 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

        // Song 1: a rest slot sounds as note 0 with note_valid high
        song_sel = 2'd1;
        pulse_play();
        step();
        step();
        expect_out("s1_first", 12'h100, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step();
        expect_out("s1_rest", 12'h000, 1'b1, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step();
        expect_out("s1_done", 12'h000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-slot clears outputs and lengths
        song_sel = 2'd0;
        pulse_play();
        step();
        step();
        step();
        expect_out("pre_rst", 12'h005, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        pulse_play();
        expect_out("rst_len_a", 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        expect_out("rst_len_b", 12'h000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
